// File: rtl/uart_tx_ts_if.sv
// Address/control half of the datapath memory bus as seen by a memory-mapped responder.
// The 64-bit data bus stays a plain inout on the responder so it can be tri-stated.
interface uart_tx_ts_if;
  logic [31:0] address;
  logic        MW;
  logic        EN;
  logic [1:0]  size;

  modport master (
    output address,
    output MW,
    output EN,
    output size
  );

  modport slave (
    input address,
    input MW,
    input EN,
    input size
  );
endinterface

// File: rtl/uart_tx_ts.sv
// Memory-mapped 8N1 UART transmitter on the shared LEGv8 bus: CPU stores bytes into a small
// TX FIFO which a serialiser shifts out LSB-first at a programmable bit period.
module uart_tx_ts #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_1000,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [63:0] data,
  uart_tx_ts_if.slave bus,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  localparam logic [1:0] RegTxData = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegBaud   = 2'd2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // ---------------------------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------------------------
  logic        sel;
  logic [1:0]  reg_idx;
  logic        wr_en;
  logic        rd_en;
  logic [63:0] size_mask;
  logic [15:0] wdata16;

  assign sel     = (bus.address[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
  assign reg_idx = bus.address[4:3];
  assign wr_en   = sel & bus.MW;
  // A write strobe always wins over a read request, so the bus is never driven during a write.
  assign rd_en   = sel & bus.EN & ~bus.MW;

  always_comb begin
    size_mask = '1;
    unique case (bus.size)
      2'b00:   size_mask = 64'h0000_0000_0000_00ff;
      2'b01:   size_mask = 64'h0000_0000_0000_ffff;
      2'b10:   size_mask = 64'h0000_0000_ffff_ffff;
      default: size_mask = 64'hffff_ffff_ffff_ffff;
    endcase
  end

  assign wdata16 = data[15:0] & size_mask[15:0];

  logic wr_tx;
  logic wr_status;
  logic wr_baud;

  assign wr_tx     = wr_en & (reg_idx == RegTxData);
  assign wr_status = wr_en & (reg_idx == RegStatus);
  assign wr_baud   = wr_en & (reg_idx == RegBaud);

  // ---------------------------------------------------------------------------------------------
  // Registers and FIFO state
  // ---------------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [15:0]     baud_q, baud_d;
  logic            overrun_q, overrun_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_done;

  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign bit_done = (cnt_q == 16'd0);

  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted then.
  assign push = wr_tx & (~full | pop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (wr_status && wdata16[3]) begin
      overrun_d = 1'b0;
    end
    if (wr_tx && !push) begin
      overrun_d = 1'b1;
    end
  end

  assign baud_d = wr_baud ? wdata16 : baud_q;

  // ---------------------------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          cnt_d   = baud_q;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_idx_d = 3'd0;
          cnt_d     = baud_q;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = baud_q;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            cnt_d   = baud_q;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      baud_q    <= DEFAULT_DIV;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      baud_q    <= baud_d;
      overrun_q <= overrun_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= data[7:0];
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != StIdle) | ~empty;

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  logic [63:0] status;
  logic [63:0] rd_val;

  assign status = {48'h0, 8'(count_q), 4'h0, overrun_q, empty, full, busy};

  always_comb begin
    rd_val = '0;
    unique case (reg_idx)
      RegStatus: rd_val = status;
      RegBaud:   rd_val = {48'h0, baud_q};
      default:   rd_val = '0;
    endcase
  end

  assign data = rd_en ? (rd_val & size_mask) : 64'bz;

  logic unused_bits;
  assign unused_bits = ^{data[63:16], bus.address[2:0]};

  count_in_range_a : assert property (@(posedge clock) disable iff (!reset) count_q <= DepthCnt);
  idle_line_high_a : assert property (@(posedge clock) disable iff (!reset)
                                      (state_q == StIdle) |-> tx_q);

endmodule

// File: tb/tb_uart_tx_ts.sv
// Randomized bench for uart_tx_ts: bus writes feed a timeline model of FIFO admission and
// frame start times; the recorded tx line is decoded against it bit period by bit period.
module tb_uart_tx_ts;

  localparam int          Depth   = 4;
  localparam logic [15:0] DefDiv  = 16'd433;
  localparam logic [31:0] Base    = 32'h8000_1000;
  localparam int          HistLen = 32768;

  localparam logic [31:0] ATx     = Base + 32'h00;
  localparam logic [31:0] AStat   = Base + 32'h08;
  localparam logic [31:0] ABaud   = Base + 32'h10;
  localparam logic [31:0] ARsvd   = Base + 32'h18;
  localparam logic [63:0] Undrv   = 64'hffff_ffff_ffff_ffff;

  logic        clock = 1'b0;
  logic        reset;
  wire  [63:0] data;
  logic [63:0] tb_wdata;
  logic        tb_drv;
  logic        tx;
  logic        busy;

  uart_tx_ts_if bus ();

  assign data = tb_drv ? tb_wdata : 64'bz;

  // Pull-ups make an undriven bus read back as all ones.
  for (genvar i = 0; i < 64; i++) begin : g_pull
    pullup (data[i]);
  end

  uart_tx_ts #(
    .BASE_ADDR  (Base),
    .ADDR_WIDTH (5),
    .FIFO_DEPTH (Depth),
    .DEFAULT_DIV(DefDiv)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data (data),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  logic tx_hist   [HistLen];
  logic busy_hist [HistLen];

  always @(posedge clock) cyc <= cyc + 1;

  // Entry n holds the line state after rising edge n.
  always @(negedge clock) begin
    if (cyc < HistLen) begin
      tx_hist[cyc]   <= tx;
      busy_hist[cyc] <= busy;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [63:0] val,
                           input logic [1:0] sz, output int edge_n);
    bus.address = addr;
    bus.size    = sz;
    bus.MW      = 1'b1;
    bus.EN      = 1'b0;
    tb_wdata    = val;
    tb_drv      = 1'b1;
    step();
    edge_n      = cyc;
    bus.MW      = 1'b0;
    tb_drv      = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [1:0] sz, output logic [63:0] val);
    bus.address = addr;
    bus.size    = sz;
    bus.MW      = 1'b0;
    bus.EN      = 1'b1;
    #1;
    val    = data;
    bus.EN = 1'b0;
    #1;
  endtask

  // Decode one frame: bit j lasts d0+1 clocks before bit sw, d1+1 from bit sw on.
  task automatic check_frame(input string tag, input int start, input int d0, input int d1,
                             input int sw, input logic [7:0] b);
    logic [9:0] obs;
    int         t;
    int         glitches;
    t        = start;
    glitches = 0;
    obs      = '0;
    for (int j = 0; j < 10; j++) begin
      int len;
      len    = (j < sw) ? d0 + 1 : d1 + 1;
      obs[j] = tx_hist[t];
      for (int c = 1; c < len; c++) begin
        if (tx_hist[t + c] !== obs[j]) glitches++;
      end
      t += len;
    end
    check({tag, "_frame"}, 64'(obs), 64'({1'b1, b, 1'b0}));
    check({tag, "_stable"}, 64'(glitches), 64'd0);
    check({tag, "_lead"}, 64'(tx_hist[start - 1]), 64'd1);
  endtask

  logic [7:0] stim [8];

  // Push n bytes from stim at divisor d; predict admission and frame timing from arithmetic.
  task automatic burst(input string tag, input int d, input int n, input bit rand_gaps);
    int          p;
    int          prev_end;
    int          n_acc;
    int          start_e [8];
    logic [7:0]  acc_b   [8];
    bit          ovr;
    int          cnt;
    logic [63:0] rd;
    bus_write(ABaud, 64'(d), 2'b10, p);
    prev_end = 0;
    n_acc    = 0;
    ovr      = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rand_gaps) repeat ($urandom_range(0, 2)) step();
      bus_write(ATx, {$urandom, $urandom_range(0, 16'hffff), 8'h00, stim[i]},
                2'(i % 4), p);
      cnt = 0;
      for (int k = 0; k < n_acc; k++) if (start_e[k] > p) cnt++;
      if (cnt < Depth) begin
        start_e[n_acc] = (p + 1 > prev_end) ? p + 1 : prev_end;
        acc_b[n_acc]   = stim[i];
        prev_end       = start_e[n_acc] + 10 * (d + 1);
        n_acc++;
      end else begin
        ovr = 1'b1;
      end
    end
    cnt = 0;
    for (int k = 0; k < n_acc; k++) if (start_e[k] > p) cnt++;
    bus_read(AStat, 2'b10, rd);
    check({tag, "_status_live"}, rd,
          64'((cnt << 8) | (int'(ovr) << 3) | (int'(cnt == 0) << 2) |
              (int'(cnt == Depth) << 1) | 1));
    wait_until(prev_end + 4);
    for (int k = 0; k < n_acc; k++) begin
      check_frame($sformatf("%s_f%0d", tag, k), start_e[k], d, d, 10, acc_b[k]);
    end
    check({tag, "_busy_stop"}, 64'(busy_hist[prev_end - 1]), 64'd1);
    check({tag, "_busy_drop"}, 64'(busy_hist[prev_end]), 64'd0);
    cnt = 0;
    for (int t = prev_end; t <= prev_end + 3; t++) if (tx_hist[t] !== 1'b1) cnt++;
    check({tag, "_idle_after"}, 64'(cnt), 64'd0);
    bus_read(AStat, 2'b11, rd);
    check({tag, "_status_end"}, rd, 64'((int'(ovr) << 3) | 4));
    if (ovr) begin
      bus_write(AStat, 64'h8, 2'b00, p);
      bus_read(AStat, 2'b10, rd);
      check({tag, "_ovr_clear"}, rd, 64'h4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd;
    int          p;
    int          s;
    int          rel;
    int          zeros;
    logic [7:0]  b;

    reset       = 1'b0;
    tb_drv      = 1'b0;
    tb_wdata    = '0;
    bus.address = '0;
    bus.MW      = 1'b0;
    bus.EN      = 1'b0;
    bus.size    = 2'b00;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Reset state
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    bus_read(AStat, 2'b10, rd);
    check("rst_status", rd, 64'h4);
    bus_read(ABaud, 2'b01, rd);
    check("rst_baud", rd, 64'(DefDiv));
    step();
    bus_read(ATx, 2'b11, rd);
    check("rd_txdata_zero", rd, 64'h0);
    bus_read(ARsvd, 2'b11, rd);
    check("rd_rsvd_zero", rd, 64'h0);
    step();

    // Single 0x55 frame at 4 clocks/bit
    stim[0] = 8'h55;
    burst("single55", 3, 1, 1'b0);

    // Six back-to-back writes into a 4-deep FIFO: 0x06 must be dropped
    for (int i = 0; i < 6; i++) stim[i] = 8'(i + 1);
    burst("overrun6", 3, 6, 1'b0);

    // Bus window, size masking and write-wins
    bus_read(32'h8000_2000, 2'b11, rd);
    check("rd_out_of_window", rd, Undrv);
    step();
    bus_write(ABaud, 64'hdead_beef_0000_1234, 2'b01, p);
    bus_read(ABaud, 2'b00, rd);
    check("rd_baud_byte", rd, 64'h34);
    bus_read(ABaud, 2'b11, rd);
    check("rd_baud_dbl", rd, 64'h1234);
    step();
    bus_read(Base + 32'h17, 2'b01, rd);
    check("rd_low_addr_ignored", rd, 64'h1234);
    bus.address = ABaud;
    bus.EN      = 1'b0;
    #1;
    check("no_en_undriven", data, Undrv);
    step();
    bus.address = ARsvd;
    bus.size    = 2'b11;
    bus.MW      = 1'b1;
    bus.EN      = 1'b1;
    #1;
    check("mw_en_undriven", data, Undrv);
    step();
    bus.MW = 1'b0;
    bus.EN = 1'b0;
    bus_write(ABaud, 64'hffff_ffff_ffff_abcd, 2'b00, p);
    bus_read(ABaud, 2'b10, rd);
    check("baud_byte_write", rd, 64'h00cd);
    step();

    // Randomized bursts, divisor down to zero
    for (int r = 0; r < 8; r++) begin
      int d;
      int n;
      d = $urandom_range(0, 3);
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
      burst($sformatf("rnd%0d", r), d, n, 1'b1);
    end

    // Divisor change from 3 to 7 during data bit 2
    bus_write(ABaud, 64'd3, 2'b10, p);
    b = 8'($urandom);
    bus_write(ATx, 64'(b), 2'b00, p);
    s = p + 1;
    wait_until(s + 12);
    bus_write(ABaud, 64'd7, 2'b01, p);
    wait_until(s + 16 + 6 * 8 + 3);
    check_frame("baud_mid", s, 3, 7, 4, b);
    check("baud_mid_done", 64'(busy_hist[s + 64]), 64'd0);

    // Reset during data bit 4 with two bytes still queued
    bus_write(ABaud, 64'd3, 2'b10, p);
    bus_write(ATx, 64'h0f, 2'b00, p);
    s = p + 1;
    bus_write(ATx, 64'hf0, 2'b00, p);
    bus_write(ATx, 64'h3c, 2'b00, p);
    wait_until(s + 21);
    bus_read(AStat, 2'b10, rd);
    check("pre_rst_status", rd, 64'h201);
    check("pre_rst_tx_low", 64'(tx), 64'd0);
    reset = 1'b0;
    #1;
    check("async_rst_tx", 64'(tx), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    bus_read(AStat, 2'b10, rd);
    check("async_rst_status", rd, 64'h4);
    bus_read(ABaud, 2'b01, rd);
    check("async_rst_baud", rd, 64'(DefDiv));
    step();
    reset = 1'b1;
    rel   = cyc + 1;
    repeat (60) step();
    zeros = 0;
    for (int t = rel; t < cyc; t++) if (tx_hist[t] !== 1'b1 || busy_hist[t] !== 1'b0) zeros++;
    check("post_rst_quiet", 64'(zeros), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
